// File: rtl/conv_window_stream.sv
// conv_window_stream: streaming KxK sliding-window generator.
// Keeps FILTER_SIZE-1 line buffers, takes one raster-order pixel beat per
// accepted handshake and emits each strided window on a valid/ready port.
// Optional build macro: CONV_WIN_COORD_EN adds win_row/win_col outputs that
// carry the top-left coordinate of the window currently on data_out.
module conv_window_stream #(
  parameter int unsigned WIDTH       = 28,
  parameter int unsigned HEIGHT      = 28,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned FILTER_SIZE = 7,
  parameter int unsigned CHANNELS    = 1,
  parameter int unsigned STRIDE      = 1
) (
  input  logic                                                       clk,
  input  logic                                                       rst,
  input  logic                                                       enable,
  input  logic                                                       in_valid,
  output logic                                                       in_ready,
  input  logic                                                       in_sof,
  input  logic [CHANNELS*DATA_BITS-1:0]                              data_in,
  output logic                                                       out_valid,
  input  logic                                                       out_ready,
  output logic [FILTER_SIZE*FILTER_SIZE*CHANNELS*(DATA_BITS+1)-1:0]  data_out,
  output logic                                                       frame_done
`ifdef CONV_WIN_COORD_EN
  ,
  output logic [$clog2(HEIGHT)-1:0]                                  win_row,
  output logic [$clog2(WIDTH)-1:0]                                   win_col
`endif
);

  localparam int unsigned K      = FILTER_SIZE;
  localparam int unsigned PIX_W  = CHANNELS * DATA_BITS;
  localparam int unsigned ELEM_W = DATA_BITS + 1;
  localparam int unsigned OUT_W  = K * K * CHANNELS * ELEM_W;
  localparam int unsigned ROW_W  = $clog2(HEIGHT);
  localparam int unsigned COL_W  = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic               out_valid_q, out_valid_d;
  logic [OUT_W-1:0]   data_out_q, data_out_d;
  logic               frame_done_q, frame_done_d;

  // lb_q[k][x] holds pixel (row-K+1+k, x); k = K-2 is the most recent row
  logic [PIX_W-1:0]   lb_q  [K-1][WIDTH];
  logic [PIX_W-1:0]   lb_d  [K-1][WIDTH];
  logic [PIX_W-1:0]   win_q [K][K];
  logic [PIX_W-1:0]   win_d [K][K];

  logic               accept;
  logic               qualify;
  logic               last_pix;
  logic [ROW_W-1:0]   row_eff;
  logic [COL_W-1:0]   col_eff;

`ifdef CONV_WIN_COORD_EN
  logic [ROW_W-1:0]   win_row_q, win_row_d;
  logic [COL_W-1:0]   win_col_q, win_col_d;
`endif

  // Input handshake: only in RUN, and never while a window is stalled
  assign in_ready   = (state_q == S_RUN) && (!out_valid_q || out_ready);
  assign out_valid  = out_valid_q;
  assign data_out   = data_out_q;
  assign frame_done = frame_done_q;
`ifdef CONV_WIN_COORD_EN
  assign win_row    = win_row_q;
  assign win_col    = win_col_q;
`endif

  // Beat position (sof forces pixel 0,0) and window qualification
  always_comb begin
    logic [31:0] r_i;
    logic [31:0] c_i;
    accept   = in_valid && in_ready;
    row_eff  = in_sof ? '0 : row_q;
    col_eff  = in_sof ? '0 : col_q;
    r_i      = 32'(row_eff);
    c_i      = 32'(col_eff);
    qualify  = (r_i >= 32'(K - 1)) && (c_i >= 32'(K - 1)) &&
               (((r_i - 32'(K - 1)) % 32'(STRIDE)) == 32'd0) &&
               (((c_i - 32'(K - 1)) % 32'(STRIDE)) == 32'd0);
    last_pix = (row_eff == ROW_W'(HEIGHT - 1)) && (col_eff == COL_W'(WIDTH - 1));
  end

  // Datapath: line-buffer column shift, window shift, output window packing
  always_comb begin
    lb_d       = lb_q;
    win_d      = win_q;
    data_out_d = data_out_q;
`ifdef CONV_WIN_COORD_EN
    win_row_d  = win_row_q;
    win_col_d  = win_col_q;
`endif
    if (accept) begin
      // Column read happens from lb_q before the same column is rewritten
      for (int unsigned r = 0; r < K; r++) begin
        for (int unsigned c = 0; c + 1 < K; c++) begin
          win_d[r][c] = win_q[r][c+1];
        end
        if (r + 1 < K) begin
          win_d[r][K-1] = lb_q[r][col_eff];
        end else begin
          win_d[r][K-1] = data_in;
        end
      end
      for (int unsigned k = 0; k + 2 < K; k++) begin
        lb_d[k][col_eff] = lb_q[k+1][col_eff];
      end
      lb_d[K-2][col_eff] = data_in;

      if (qualify) begin
        for (int unsigned r = 0; r < K; r++) begin
          for (int unsigned c = 0; c < K; c++) begin
            for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
              data_out_d[((r*K + c)*CHANNELS + ch)*ELEM_W +: ELEM_W] =
                ELEM_W'({1'b0, win_d[r][c][ch*DATA_BITS +: DATA_BITS]});
            end
          end
        end
`ifdef CONV_WIN_COORD_EN
        win_row_d = row_eff - ROW_W'(K - 1);
        win_col_d = col_eff - COL_W'(K - 1);
`endif
      end
    end
  end

  // Control FSM: frame start, raster counters, output valid, drain and done
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    out_valid_d  = out_valid_q;
    frame_done_d = 1'b0;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (accept) begin
          if (qualify) begin
            out_valid_d = 1'b1;
          end
          if (last_pix) begin
            state_d = S_DRAIN;
            row_d   = '0;
            col_d   = '0;
          end else if (col_eff == COL_W'(WIDTH - 1)) begin
            col_d = '0;
            row_d = row_eff + ROW_W'(1);
          end else begin
            col_d = col_eff + COL_W'(1);
            row_d = row_eff;
          end
        end
      end
      S_DRAIN: begin
        if (!out_valid_q || out_ready) begin
          frame_done_d = 1'b1;
          state_d      = S_IDLE;
          row_d        = '0;
          col_d        = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      row_q        <= '0;
      col_q        <= '0;
      out_valid_q  <= 1'b0;
      data_out_q   <= '0;
      frame_done_q <= 1'b0;
`ifdef CONV_WIN_COORD_EN
      win_row_q    <= '0;
      win_col_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      out_valid_q  <= out_valid_d;
      data_out_q   <= data_out_d;
      frame_done_q <= frame_done_d;
`ifdef CONV_WIN_COORD_EN
      win_row_q    <= win_row_d;
      win_col_q    <= win_col_d;
`endif
    end
  end

  // Line buffers and window register carry no reset; a new frame refills them
  always_ff @(posedge clk) begin
    lb_q  <= lb_d;
    win_q <= win_d;
  end

endmodule

// File: tb/tb_conv_window_stream.sv
// tb_conv_window_stream: randomized bench with an image-array reference model.
// Two instances share one pixel stream: dut_a (STRIDE=1, backpressured) and
// dut_b (STRIDE=2, always ready, fed only with beats dut_a accepts).
module tb_conv_window_stream;

  localparam int W    = 6;
  localparam int H    = 6;
  localparam int K    = 3;
  localparam int CH   = 2;
  localparam int DB   = 8;
  localparam int EW   = DB + 1;
  localparam int IN_W = CH * DB;
  localparam int OUT_W = K * K * CH * EW;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              enable = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_sof = 1'b0;
  logic [IN_W-1:0]   data_in = '0;
  logic              out_ready = 1'b0;

  logic              a_in_ready, a_out_valid, a_frame_done;
  logic [OUT_W-1:0]  a_data_out;
  logic              b_in_valid, b_in_ready, b_out_valid, b_frame_done;
  logic [OUT_W-1:0]  b_data_out;
`ifdef CONV_WIN_COORD_EN
  logic [$clog2(H)-1:0] a_win_row, b_win_row;
  logic [$clog2(W)-1:0] a_win_col, b_win_col;
`endif

  assign b_in_valid = in_valid && a_in_ready;

  always #5 clk = ~clk;

  conv_window_stream #(
    .WIDTH(W), .HEIGHT(H), .DATA_BITS(DB), .FILTER_SIZE(K), .CHANNELS(CH), .STRIDE(1)
  ) dut_a (
    .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_sof(in_sof), .data_in(data_in), .out_valid(a_out_valid), .out_ready(out_ready),
    .data_out(a_data_out), .frame_done(a_frame_done)
`ifdef CONV_WIN_COORD_EN
    , .win_row(a_win_row), .win_col(a_win_col)
`endif
  );

  conv_window_stream #(
    .WIDTH(W), .HEIGHT(H), .DATA_BITS(DB), .FILTER_SIZE(K), .CHANNELS(CH), .STRIDE(2)
  ) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_sof(in_sof), .data_in(data_in), .out_valid(b_out_valid), .out_ready(1'b1),
    .data_out(b_data_out), .frame_done(b_frame_done)
`ifdef CONV_WIN_COORD_EN
    , .win_row(b_win_row), .win_col(b_win_col)
`endif
  );

  int checks = 0;
  int errors = 0;
  int ready_mode = 0;   // 0: hold low, 1: hold high, 2: random
  bit armed = 1'b0;

  // Reference model: the frame as an image, raster position, expected windows
  logic [IN_W-1:0]  pix [2][H][W];
  int               mrow [2];
  int               mcol [2];
  logic [OUT_W-1:0] qa [$];
  logic [OUT_W-1:0] qb [$];
  int               win_cnt [2];
  int               fd_cnt [2];

  task automatic chk(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [OUT_W-1:0] build_win(input int d, input int tr, input int tc);
    logic [OUT_W-1:0] v = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        for (int ch = 0; ch < CH; ch++)
          v[((r*K + c)*CH + ch)*EW +: EW] = {1'b0, pix[d][tr+r][tc+c][ch*DB +: DB]};
    return v;
  endfunction

  // Literal window: channel 0 from the listed pixel values, channel 1 = 0xFF
  function automatic logic [OUT_W-1:0] lit_win(input int vals [9]);
    logic [OUT_W-1:0] v = '0;
    for (int e = 0; e < 9; e++) begin
      v[(e*CH + 0)*EW +: EW] = EW'(vals[e]);
      v[(e*CH + 1)*EW +: EW] = 9'h0FF;
    end
    return v;
  endfunction

  task automatic model_beat(input int d, input logic [IN_W-1:0] din, input logic sof);
    int s = (d == 0) ? 1 : 2;
    int r, c;
    if (sof) begin
      mrow[d] = 0;
      mcol[d] = 0;
    end
    r = mrow[d];
    c = mcol[d];
    pix[d][r][c] = din;
    if (r >= K-1 && c >= K-1 && (r-K+1) % s == 0 && (c-K+1) % s == 0) begin
      if (d == 0) qa.push_back(build_win(d, r-K+1, c-K+1));
      else        qb.push_back(build_win(d, r-K+1, c-K+1));
    end
    mcol[d]++;
    if (mcol[d] == W) begin
      mcol[d] = 0;
      mrow[d]++;
      if (mrow[d] == H) mrow[d] = 0;
    end
  endtask

  task automatic check_port(input int d, input logic ov, input logic [OUT_W-1:0] dout,
                            input logic ordy, input logic acc, input logic [IN_W-1:0] din,
                            input logic sof, input logic fd);
    int qs = (d == 0) ? qa.size() : qb.size();
    logic [OUT_W-1:0] front = '0;
    if (qs > 0) front = (d == 0) ? qa[0] : qb[0];
    checks++;
    if (ov !== (qs > 0)) begin
      errors++;
      $display("FAIL out_valid dut%0d got %0b expected %0b at %0t", d, ov, (qs > 0), $time);
    end
    if (ov === 1'b1 && qs > 0) begin
      checks++;
      if (dout !== front) begin
        errors++;
        $display("FAIL window dut%0d got %0h expected %0h at %0t", d, dout, front, $time);
      end
      if (ordy) begin
        if (d == 0) void'(qa.pop_front());
        else        void'(qb.pop_front());
        win_cnt[d]++;
      end
    end
    if (fd === 1'b1) fd_cnt[d]++;
    if (acc) model_beat(d, din, sof);
  endtask

  // Per-cycle compare of both instances against the model, away from the clock edge
  always @(negedge clk) begin
    if (rst) begin
      qa.delete();
      qb.delete();
      mrow[0] = 0; mrow[1] = 0;
      mcol[0] = 0; mcol[1] = 0;
      armed = 1'b1;
    end else if (armed) begin
      check_port(0, a_out_valid, a_data_out, out_ready, in_valid && a_in_ready,
                 data_in, in_sof, a_frame_done);
      check_port(1, b_out_valid, b_data_out, 1'b1, b_in_valid && b_in_ready,
                 data_in, in_sof, b_frame_done);
    end
  end

  // Consumer ready driver
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  task automatic send_beat(input logic [IN_W-1:0] d, input logic sof);
    int n = 0;
    in_valid = 1'b1;
    data_in  = d;
    in_sof   = sof;
    do begin
      @(negedge clk);
      n++;
    end while (!a_in_ready && n < 200);
    if (!a_in_ready) begin
      errors++;
      $display("FAIL beat_timeout got in_ready=0 expected 1 at %0t", $time);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic send_random(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send_beat(IN_W'($urandom), 1'b0);
    end
  endtask

  task automatic wait_frame(input int pfa, input int pfb, input int pwa, input int pwb);
    int n = 0;
    while ((fd_cnt[0] == pfa || fd_cnt[1] == pfb) && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(posedge clk);
    #1;
    chk("frame_done_a", OUT_W'(fd_cnt[0] - pfa), OUT_W'(1));
    chk("frame_done_b", OUT_W'(fd_cnt[1] - pfb), OUT_W'(1));
    chk("windows_a", OUT_W'(win_cnt[0] - pwa), OUT_W'(16));
    chk("windows_b", OUT_W'(win_cnt[1] - pwb), OUT_W'(4));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got no finish expected finish at %0t", $time);
    $fatal(1);
  end

  initial begin
    int first_l [9];
    int last_l [9];
    int b2_l [9];
    int pfa, pfb, pwa, pwb;
    logic [OUT_W-1:0] held;
    int n;
    first_l = '{0, 1, 2, 6, 7, 8, 12, 13, 14};
    last_l  = '{21, 22, 23, 27, 28, 29, 33, 34, 35};
    b2_l    = '{2, 3, 4, 8, 9, 10, 14, 15, 16};
    for (int d = 0; d < 2; d++) begin
      win_cnt[d] = 0;
      fd_cnt[d]  = 0;
      mrow[d]    = 0;
      mcol[d]    = 0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", OUT_W'(a_out_valid), '0);
    chk("rst_in_ready", OUT_W'(a_in_ready), '0);
    chk("rst_data_out", a_data_out, '0);
    chk("rst_frame_done", OUT_W'(a_frame_done), '0);

    // Frame 1: index pattern, full rate, always ready
    enable = 1'b1;
    ready_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("run_in_ready", OUT_W'(a_in_ready), OUT_W'(1));
    pfa = fd_cnt[0]; pfb = fd_cnt[1]; pwa = win_cnt[0]; pwb = win_cnt[1];
    for (int i = 0; i < W*H; i++) begin
      send_beat({8'hFF, 8'(i)}, 1'b0);
      if (i == 13) chk("latency_pre", OUT_W'(a_out_valid), '0);
      if (i == 14) begin
        chk("latency_first", OUT_W'(a_out_valid), OUT_W'(1));
        chk("first_window", a_data_out, lit_win(first_l));
        chk("elem_zero_ext", OUT_W'(a_data_out[EW +: EW]), OUT_W'(9'h0FF));
        chk("s2_first_valid", OUT_W'(b_out_valid), OUT_W'(1));
        chk("s2_first_window", b_data_out, lit_win(first_l));
      end
      if (i == 15) chk("s2_col3_none", OUT_W'(b_out_valid), '0);
      if (i == 16) begin
        chk("s2_col4_valid", OUT_W'(b_out_valid), OUT_W'(1));
        chk("s2_col4_window", b_data_out, lit_win(b2_l));
      end
      if (i == 17) chk("s2_col5_none", OUT_W'(b_out_valid), '0);
      if (i == W*H-1) chk("last_window", a_data_out, lit_win(last_l));
    end
    wait_frame(pfa, pfb, pwa, pwb);

    // Frame 2: consumer stalls on the first window, then random ready
    ready_mode = 0;
    pfa = fd_cnt[0]; pfb = fd_cnt[1]; pwa = win_cnt[0]; pwb = win_cnt[1];
    fork
      send_random(W*H, 1'b1);
      begin
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!a_out_valid && n < 400);
        chk("stall_window_seen", OUT_W'(a_out_valid), OUT_W'(1));
        held = a_data_out;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          chk("stall_in_ready", OUT_W'(a_in_ready), '0);
          chk("stall_out_valid", OUT_W'(a_out_valid), OUT_W'(1));
          chk("stall_data_hold", a_data_out, held);
        end
        ready_mode = 2;
      end
    join
    wait_frame(pfa, pfb, pwa, pwb);

    // Frame 3: reset in the middle of the frame
    ready_mode = 2;
    pfa = fd_cnt[0];
    send_random(20, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", OUT_W'(a_out_valid), '0);
    chk("midrst_in_ready", OUT_W'(a_in_ready), '0);
    chk("midrst_data_out", a_data_out, '0);
    chk("midrst_frame_done", OUT_W'(a_frame_done), '0);
    chk("midrst_b_valid", OUT_W'(b_out_valid), '0);
    chk("midrst_no_done", OUT_W'(fd_cnt[0] - pfa), '0);

    // Frame 4: complete random frame after the reset
    repeat (2) @(posedge clk);
    #1;
    pfa = fd_cnt[0]; pfb = fd_cnt[1]; pwa = win_cnt[0]; pwb = win_cnt[1];
    send_random(W*H, 1'b1);
    wait_frame(pfa, pfb, pwa, pwb);

    // Frame 5: partial frame abandoned by sof, then the index frame
    ready_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    pfa = fd_cnt[0]; pfb = fd_cnt[1]; pwa = win_cnt[0]; pwb = win_cnt[1];
    send_random(10, 1'b0);
    for (int i = 0; i < W*H; i++) begin
      send_beat({8'hFF, 8'(i)}, (i == 0));
      if (i == 14) chk("sof_first_window", a_data_out, lit_win(first_l));
      if (i == W*H-1) chk("sof_last_window", a_data_out, lit_win(last_l));
    end
    wait_frame(pfa, pfb, pwa, pwb);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_window_stream.md
Name: conv_window_stream

Overview:
- Streaming successor to the frame-buffered convolution window generator.
- Holds only FILTER_SIZE-1 line buffers instead of a full frame.
- Accepts a raster-order pixel stream carrying CHANNELS packed samples per beat.
- Emits every valid KxK sliding window at a programmable stride through a valid/ready handshake with backpressure; feeds the conv MAC array.

Parameters:
- WIDTH, 28, frame width in pixels (>= FILTER_SIZE).
- HEIGHT, 28, frame height in pixels (>= FILTER_SIZE).
- DATA_BITS, 8, unsigned bits per channel sample.
- FILTER_SIZE, 7, window edge K (>= 2).
- CHANNELS, 1, samples per pixel beat.
- STRIDE, 1, window step in both dimensions (>= 1).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  permits frame start; sampled in IDLE.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts beat when in_valid && in_ready.
- in_sof  in  1  start-of-frame marker, qualified by in_valid.
- data_in  in  CHANNELS*DATA_BITS  pixel; channel ch at bits [ch*DATA_BITS +: DATA_BITS].
- out_valid  out  1  window valid.
- out_ready  in  1  consumer accepts window.
- data_out  out  K*K*CHANNELS*(DATA_BITS+1)  window. Element e=(r*K+c)*CHANNELS+ch sits at [e*(DATA_BITS+1) +: DATA_BITS+1]. Each element is signed, zero-extended from the unsigned input.
- frame_done  out  1  one-cycle pulse after the last window of a frame is accepted.

Behaviour:
- Reset (rst=1 at a clock edge):
  - in_ready=0, out_valid=0, frame_done=0, data_out=0.
  - Row/col counters cleared; state=IDLE.
  - Line buffer contents are don't-care.
  - Reset overrides every other input in that cycle, including mid-frame.
- States:
  - IDLE: in_ready=0. Moves to RUN on the next edge when enable=1.
  - RUN: in_ready = !out_valid || out_ready.
    - On each accepted beat: write the pixel into the line buffers at column col, shift the KxK window register one column left, load the new rightmost column from line buffers rows row-K+1..row-1 plus data_in.
    - Then advance col; on col==WIDTH-1 wrap col to 0 and increment row.
  - DRAIN: entered after pixel (HEIGHT-1, WIDTH-1) is accepted. in_ready=0.
    - Waits until out_valid==0, or out_valid && out_ready.
    - Then pulses frame_done for one cycle, returns to IDLE and clears row/col.
- Window emission:
  - The beat at (row,col) qualifies when row>=K-1, col>=K-1, (row-K+1)%STRIDE==0 and (col-K+1)%STRIDE==0.
  - Latency: out_valid=1 and data_out are updated on the edge that accepts the qualifying beat, i.e. they are visible one cycle after acceptance.
  - data_out holds the window whose top-left pixel is (row-K+1, col-K+1); element (r,c) = pixel (row-K+1+r, col-K+1+c).
  - out_valid && !out_ready: data_out and out_valid hold stable, and in_ready=0 (no overwrite).
  - out_valid && out_ready with no new qualifying beat: out_valid drops next cycle.
  - Accept and new qualifying beat in the same cycle: out_valid stays 1 and data_out is replaced (back-to-back, one window per clock).
- Windows per frame: ((WIDTH-K)/STRIDE+1) * ((HEIGHT-K)/STRIDE+1). Integer division; trailing columns/rows not reached by the stride produce no window.
- Line-buffer wrap: the row-K+1 data is overwritten only after it has been read for the current column.
- in_sof:
  - Accepted with in_sof=1 in RUN: that beat is pixel (0,0) regardless of the counters. The partial frame is abandoned, no frame_done is pulsed, and a pending out_valid is kept until accepted.
  - in_sof is ignored in IDLE/DRAIN, where in_ready=0.
- enable=0 in RUN/DRAIN has no effect; it is only checked in IDLE.

Optional Feature:
- Macro CONV_WIN_COORD_EN.
- When defined, adds outputs win_row and win_col, each $clog2(HEIGHT) and $clog2(WIDTH) bits respectively. They carry the top-left coordinate of the window on data_out, update together with data_out, and reset to 0.
- When undefined, the ports do not exist and the logic is removed; all other behaviour is identical.

Test Plan:
- WIDTH=HEIGHT=6, K=3, STRIDE=1, CHANNELS=1, pixel value = index 0..35, out_ready=1 -> 16 windows.
  - First out_valid one cycle after beat 14 is accepted, data_out = {0,1,2,6,7,8,12,13,14}.
  - Last window = {21,22,23,27,28,29,33,34,35}.
  - frame_done pulses once.
- Same frame with STRIDE=2 -> exactly 4 windows, top-left coordinates (0,0),(0,2),(2,0),(2,2). Beats at cols 3 and 5 produce no window.
- out_ready held 0 for 5 cycles after the first window -> in_ready=0, data_out and out_valid stable throughout, no beat lost. Window sequence is identical to the first scenario.
- CHANNELS=2, DATA_BITS=8, input sample 8'hFF -> each element is 9'h0FF (zero-extended, positive).
- rst asserted for one cycle at beat 20 of a frame -> outputs go to reset values next cycle. A subsequent frame with enable=1 yields the full 16 correct windows.
- in_sof asserted on beat 10 of a frame -> counters restart at that beat; the next 36 beats yield 16 windows matching the first scenario, with no frame_done for the abandoned frame.
